// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter with a polled status register.
// Define UART_TX_BUFFER_EN to add a one-byte holding register for gapless frames.
module uart_tx_device #(
  parameter int unsigned CLK_FREQ         = 27_000_000,
  parameter int unsigned BAUD_RATE        = 9600,
  parameter logic [31:0] ADDRESS_UART_OUT = 32'h0000_000e
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        write_enable,
  output logic [31:0] data_out,
  output logic        uart_tx
);

  localparam int unsigned BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW       = (BIT_TIME > 2) ? $clog2(BIT_TIME) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_TIME - 1);

  generate
    if (BIT_TIME < 2) begin : g_bit_time_check
      $error("uart_tx_device: CLK_FREQ / BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            full;
  logic            accept;
  logic            bit_end;
  logic            unused_upper;

`ifdef UART_TX_BUFFER_EN
  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  assign full = hold_vld_q;
`else
  assign full = (state_q != IDLE);
`endif

  assign accept       = write_enable && (address == ADDRESS_UART_OUT) && !full;
  assign bit_end      = (cnt_q == CNT_LAST);
  assign unused_upper = ^data_in[31:8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_BUFFER_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          shift_d = data_in[7:0];
          state_d = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
`ifdef UART_TX_BUFFER_EN
          // Held byte wins; otherwise a write landing now bypasses straight in.
          if (hold_vld_q) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            state_d    = START;
          end else if (accept) begin
            shift_d = data_in[7:0];
            state_d = START;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_BUFFER_EN
    if (accept && (state_q != IDLE) && !((state_q == STOP) && bit_end)) begin
      hold_d     = data_in[7:0];
      hold_vld_d = 1'b1;
    end
`endif
    if (state_d != state_q) begin
      cnt_d = '0;
      bit_d = '0;
    end
    // Line level is registered from the next state so it changes with the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_BUFFER_EN
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_BUFFER_EN
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`endif
    end
  end

  assign uart_tx  = tx_q;
  assign data_out = (address == ADDRESS_UART_OUT) ? {31'b0, full} : 32'h0000_0000;

endmodule

// File: tb/tb_uart_tx_device.sv
// Directed bench for uart_tx_device at BIT_TIME = 4 (CLK_FREQ 40, BAUD_RATE 10).
module tb_uart_tx_device;

  localparam logic [31:0] ADDR = 32'h0000_000e;
`ifdef UART_TX_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;
  logic        uart_tx;

  int total = 0;
  int bad   = 0;

  uart_tx_device #(
    .CLK_FREQ        (40),
    .BAUD_RATE       (10),
    .ADDRESS_UART_OUT(ADDR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .data_in     (data_in),
    .write_enable(write_enable),
    .data_out    (data_out),
    .uart_tx     (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the accept edge (k = 0..39).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int j;
    j = k / 4;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; write_enable = 1'b0; address = ADDR; data_in = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    total++;
    if (uart_tx !== 1'b1) begin
      bad++; $display("FAIL reset_tx got=%b want=1", uart_tx);
    end
    total++;
    if (data_out !== 32'h0) begin
      bad++; $display("FAIL reset_status got=%h want=00000000", data_out);
    end
    address = 32'h0; #1;
    total++;
    if (data_out !== 32'h0) begin
      bad++; $display("FAIL reset_read_addr0 got=%h want=00000000", data_out);
    end
    address = ADDR;
  endtask

  task automatic test_single_frame();
    logic [31:0] want_stat;
    want_stat = {31'b0, !BUF};
    address = ADDR; data_in = 32'h0000_0155; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
    for (int k = 0; k < 40; k++) begin
      total++;
      if (uart_tx !== frame_bit(8'h55, k)) begin
        bad++; $display("FAIL single_tx k=%0d got=%b want=%b", k, uart_tx, frame_bit(8'h55, k));
      end
      total++;
      if (data_out !== want_stat) begin
        bad++; $display("FAIL single_status k=%0d got=%h want=%h", k, data_out, want_stat);
      end
      if (k == 20) begin
        address = 32'h0; #1;
        total++;
        if (data_out !== 32'h0) begin
          bad++; $display("FAIL single_other_read got=%h want=00000000", data_out);
        end
        address = ADDR;
      end
      step();
    end
    total++;
    if (uart_tx !== 1'b1) begin
      bad++; $display("FAIL single_idle_tx got=%b want=1", uart_tx);
    end
    total++;
    if (data_out !== 32'h0) begin
      bad++; $display("FAIL single_status_end got=%h want=00000000", data_out);
    end
  endtask

  task automatic test_back_to_back();
    address = ADDR; data_in = 32'h81; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
    for (int k = 0; k < 40; k++) begin
      total++;
      if (uart_tx !== frame_bit(8'h81, k)) begin
        bad++; $display("FAIL b2b_first_tx k=%0d got=%b want=%b", k, uart_tx, frame_bit(8'h81, k));
      end
      step();
    end
    total++;
    if (uart_tx !== 1'b1 || data_out !== 32'h0) begin
      bad++; $display("FAIL b2b_idle tx=%b status=%h want tx=1 status=00000000", uart_tx, data_out);
    end
    data_in = 32'h3C; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
    for (int k = 0; k < 40; k++) begin
      total++;
      if (uart_tx !== frame_bit(8'h3C, k)) begin
        bad++; $display("FAIL b2b_second_tx k=%0d got=%b want=%b", k, uart_tx, frame_bit(8'h3C, k));
      end
      step();
    end
    total++;
    if (uart_tx !== 1'b1 || data_out !== 32'h0) begin
      bad++; $display("FAIL b2b_end tx=%b status=%h want tx=1 status=00000000", uart_tx, data_out);
    end
  endtask

  task automatic test_busy_write();
    logic        want_tx;
    logic [31:0] want_stat;
    address = ADDR; data_in = 32'hA5; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
    for (int k = 0; k < 90; k++) begin
      if (k < 40)            want_tx = frame_bit(8'hA5, k);
      else if (BUF && k < 80) want_tx = frame_bit(8'h3C, k - 40);
      else                   want_tx = 1'b1;
      want_stat = {31'b0, BUF ? (k >= 10 && k < 40) : (k < 40)};
      total++;
      if (uart_tx !== want_tx) begin
        bad++; $display("FAIL busy_tx k=%0d got=%b want=%b", k, uart_tx, want_tx);
      end
      total++;
      if (data_out !== want_stat) begin
        bad++; $display("FAIL busy_status k=%0d got=%h want=%h", k, data_out, want_stat);
      end
      write_enable = (k == 9) || (k == 19);
      data_in      = (k == 9) ? 32'h3C : 32'h77;
      step();
    end
    write_enable = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    address = ADDR; data_in = 32'hFF; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
    for (int k = 0; k < 15; k++) begin
      total++;
      if (uart_tx !== frame_bit(8'hFF, k)) begin
        bad++; $display("FAIL midrst_tx k=%0d got=%b want=%b", k, uart_tx, frame_bit(8'hFF, k));
      end
      write_enable = (k == 4);
      data_in      = 32'h00;
      rst_n        = (k != 14);
      step();
    end
    write_enable = 1'b0;
    total++;
    if (uart_tx !== 1'b1) begin
      bad++; $display("FAIL midrst_abort got=%b want=1", uart_tx);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      total++;
      if (uart_tx !== 1'b1 || data_out !== 32'h0) begin
        bad++; $display("FAIL midrst_after k=%0d tx=%b status=%h want tx=1 status=00000000", k, uart_tx, data_out);
      end
    end
  endtask

  task automatic test_wrong_address();
    address = 32'h0000_000d; data_in = 32'h00; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
    for (int k = 0; k < 50; k++) begin
      total++;
      if (uart_tx !== 1'b1 || data_out !== 32'h0) begin
        bad++; $display("FAIL wrongaddr k=%0d tx=%b read=%h want tx=1 read=00000000", k, uart_tx, data_out);
      end
      step();
    end
    address = ADDR; #1;
    total++;
    if (data_out !== 32'h0) begin
      bad++; $display("FAIL wrongaddr_status got=%h want=00000000", data_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_write();
    test_reset_mid_frame();
    test_wrong_address();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
